// File: rtl/snake_dir_ctrl.sv
// Purpose : turn four raw pushbuttons into the committed snake direction code (0=r,1=l,2=u,3=d,4=stopped).
// Latency : press pulse DEBOUNCE_CYCLES+2 cycles after a raw edge; bcd changes the cycle after tick/halt/restart.
// Backpressure: none; one pending turn is held and a newer press overwrites it.
//
// Ports:
//   clk, rst_n                    clock, async active-low reset
//   btn_r, btn_l, btn_u, btn_d    raw active-high buttons, asynchronous to clk
//   tick                          one-cycle game-step pulse; the only time a turn is committed
//   halt                          one-cycle stop request (collision)
//   restart                       one-cycle request to leave STOPPED
//   bcd                           registered direction code
//   moving                        high while running
//   turn_rejected                 one-cycle pulse after a tick that dropped a reversing turn
module snake_dir_ctrl #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_r,
    input  logic       btn_l,
    input  logic       btn_u,
    input  logic       btn_d,
    input  logic       tick,
    input  logic       halt,
    input  logic       restart,
    output logic [2:0] bcd,
    output logic       moving,
    output logic       turn_rejected
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [2:0]       CODE_STOP = 3'b100;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        STOPPED = 2'd2
    } state_t;

    // Bit index equals the direction code, so the priority encoder output is the code itself.
    logic [3:0] raw;
    logic [3:0] sync1;
    logic [3:0] sync2;
    logic [3:0] deb;
    logic [3:0] press;

    assign raw = {btn_d, btn_u, btn_l, btn_r};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 4'b0;
            sync2 <= 4'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    for (genvar i = 0; i < 4; i++) begin : g_btn
        logic [CNT_W-1:0] cnt;
        logic             deb_q;

        // Counts consecutive samples that disagree with the accepted level; the level
        // flips on the DEBOUNCE_CYCLES-th one and any agreeing sample restarts the count.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt   <= '0;
                deb_q <= 1'b0;
            end else if (sync2[i] != deb_q) begin
                if (cnt == CNT_LAST) begin
                    deb_q <= sync2[i];
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end else begin
                cnt <= '0;
            end
        end

        assign deb[i] = deb_q;
        // Press pulse is the cycle in which the level is about to rise, so the FSM sees
        // it on the same edge that the debounced level is updated.
        assign press[i] = sync2[i] & ~deb_q & (cnt == CNT_LAST);
    end

    // Priority r > l > u > d among simultaneous presses.
    logic       press_v;
    logic [1:0] press_code;

    always_comb begin
        press_v    = |press;
        press_code = 2'd0;
        if (press[0]) begin
            press_code = 2'd0;
        end else if (press[1]) begin
            press_code = 2'd1;
        end else if (press[2]) begin
            press_code = 2'd2;
        end else if (press[3]) begin
            press_code = 2'd3;
        end
    end

    state_t     state;
    logic       pend_v;
    logic [1:0] pend_code;

    // A same-cycle press is newer than anything pending, so it takes precedence.
    logic       cand_v;
    logic [1:0] cand_code;
    logic       cand_reverse;

    always_comb begin
        cand_v       = press_v | pend_v;
        cand_code    = press_v ? press_code : pend_code;
        // Opposite directions differ only in bit 0 (0<->1, 2<->3).
        cand_reverse = (cand_code == {bcd[1], ~bcd[0]});
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            bcd           <= CODE_STOP;
            moving        <= 1'b0;
            turn_rejected <= 1'b0;
            pend_v        <= 1'b0;
            pend_code     <= 2'd0;
        end else begin
            turn_rejected <= 1'b0;
            case (state)
                IDLE, RUN: begin
                    if (halt) begin
                        state  <= STOPPED;
                        bcd    <= CODE_STOP;
                        moving <= 1'b0;
                        pend_v <= 1'b0;
                    end else if (tick) begin
                        pend_v <= 1'b0;
                        if (cand_v) begin
                            if (state == IDLE) begin
                                state  <= RUN;
                                moving <= 1'b1;
                                bcd    <= {1'b0, cand_code};
                            end else if (cand_reverse) begin
                                turn_rejected <= 1'b1;
                            end else begin
                                bcd <= {1'b0, cand_code};
                            end
                        end
                    end else if (press_v) begin
                        pend_v    <= 1'b1;
                        pend_code <= press_code;
                    end
                end
                STOPPED: begin
                    bcd    <= CODE_STOP;
                    moving <= 1'b0;
                    pend_v <= 1'b0;
                    if (restart) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state  <= IDLE;
                    bcd    <= CODE_STOP;
                    moving <= 1'b0;
                    pend_v <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_snake_dir_ctrl.sv
// Purpose : self-checking bench for snake_dir_ctrl with DEBOUNCE_CYCLES=4.
// Latency : one step per clock; outputs compared 1 time unit after each rising edge.
// Backpressure: not applicable.
module tb_snake_dir_ctrl;

    localparam int N = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       btn_r = 1'b0;
    logic       btn_l = 1'b0;
    logic       btn_u = 1'b0;
    logic       btn_d = 1'b0;
    logic       tick = 1'b0;
    logic       halt = 1'b0;
    logic       restart = 1'b0;
    logic [2:0] bcd;
    logic       moving;
    logic       turn_rejected;

    int vectors = 0;
    int miscompares = 0;

    snake_dir_ctrl #(.DEBOUNCE_CYCLES(N), .CNT_W(3)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .btn_r         (btn_r),
        .btn_l         (btn_l),
        .btn_u         (btn_u),
        .btn_d         (btn_d),
        .tick          (tick),
        .halt          (halt),
        .restart       (restart),
        .bcd           (bcd),
        .moving        (moving),
        .turn_rejected (turn_rejected)
    );

    always #5 clk = ~clk;

    // Reference model: raw button history per edge since reset, accepted levels,
    // and the game state as plain variables (direction 4 = stopped / none).
    int hist[4][$];
    int m_deb[4];
    int m_dir;
    bit m_running;
    bit m_stopped;
    int m_pend;
    bit m_rej;
    int opp[4] = '{1, 0, 3, 2};

    function automatic void model_reset();
        for (int b = 0; b < 4; b++) begin
            hist[b].delete();
            m_deb[b] = 0;
        end
        m_dir     = 4;
        m_running = 1'b0;
        m_stopped = 1'b0;
        m_pend    = -1;
        m_rej     = 1'b0;
    endfunction

    // Synchronised value used at edge k is the raw value sampled two edges earlier.
    function automatic int synced(int b, int k);
        if (k < 2) return 0;
        return hist[b][k-2];
    endfunction

    function automatic void model_edge(bit [3:0] b, bit t, bit h, bit rs);
        int k;
        int pc;
        int cand;
        bit flip;
        k  = hist[0].size();
        pc = -1;
        for (int i = 0; i < 4; i++) begin
            flip = 1'b1;
            for (int j = 0; j < N; j++) begin
                if (synced(i, k - j) == m_deb[i]) flip = 1'b0;
            end
            if (flip) begin
                if (m_deb[i] == 0 && pc < 0) pc = i;
                m_deb[i] = 1 - m_deb[i];
            end
        end
        for (int i = 0; i < 4; i++) hist[i].push_back(int'(b[i]));

        m_rej = 1'b0;
        if (m_stopped) begin
            if (rs) m_stopped = 1'b0;
        end else if (h) begin
            m_stopped = 1'b1;
            m_running = 1'b0;
            m_dir     = 4;
            m_pend    = -1;
        end else if (t) begin
            cand   = (pc >= 0) ? pc : m_pend;
            m_pend = -1;
            if (cand >= 0) begin
                if (!m_running) begin
                    m_dir     = cand;
                    m_running = 1'b1;
                end else if (cand == opp[m_dir]) begin
                    m_rej = 1'b1;
                end else begin
                    m_dir = cand;
                end
            end
        end else if (pc >= 0) begin
            m_pend = pc;
        end
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input bit [3:0] b, input bit t, input bit h, input bit rs);
        {btn_d, btn_u, btn_l, btn_r} = b;
        tick    = t;
        halt    = h;
        restart = rs;
        @(posedge clk);
        model_edge(b, t, h, rs);
        #1;
        vectors++;
        chk("bcd", 32'(bcd), 32'(m_dir));
        chk("moving", 32'(moving), 32'(m_running));
        chk("turn_rejected", 32'(turn_rejected), 32'(m_rej));
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(4'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic press(input bit [3:0] b, input int hold, input int rel);
        for (int i = 0; i < hold; i++) step(b, 1'b0, 1'b0, 1'b0);
        idle(rel);
    endtask

    bit [3:0] cur;
    int       hold;
    bit       t;
    bit       h;
    bit       rs;

    initial begin
        model_reset();
        #12;
        chk("reset_bcd", 32'(bcd), 32'd4);
        chk("reset_moving", 32'(moving), 32'd0);
        chk("reset_rej", 32'(turn_rejected), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // 1: steady right press, then tick starts the run
        for (int i = 0; i < 10; i++) step(4'b0001, 1'b0, 1'b0, 1'b0);
        step(4'b0, 1'b1, 1'b0, 1'b0);
        chk("t1_bcd", 32'(bcd), 32'd0);
        chk("t1_moving", 32'(moving), 32'd1);
        idle(8);

        // 2: bouncing up button never settles long enough
        for (int i = 0; i < 20; i++) step(((i / 2) % 2 == 0) ? 4'b0100 : 4'b0000, 1'b0, 1'b0, 1'b0);
        idle(8);
        step(4'b0, 1'b1, 1'b0, 1'b0);
        chk("t2_bcd", 32'(bcd), 32'd0);
        chk("t2_rej", 32'(turn_rejected), 32'd0);

        // 3: reversal right->left is dropped with a one-cycle pulse
        press(4'b0010, 8, 4);
        step(4'b0, 1'b1, 1'b0, 1'b0);
        chk("t3_bcd", 32'(bcd), 32'd0);
        chk("t3_rej_hi", 32'(turn_rejected), 32'd1);
        idle(1);
        chk("t3_rej_lo", 32'(turn_rejected), 32'd0);
        idle(6);

        // 4: latest press wins; simultaneous presses resolved by priority
        press(4'b0100, 8, 6);
        press(4'b1000, 8, 6);
        step(4'b0, 1'b1, 1'b0, 1'b0);
        chk("t4_latest", 32'(bcd), 32'd3);
        press(4'b0001, 8, 6);
        step(4'b0, 1'b1, 1'b0, 1'b0);
        chk("t4_right", 32'(bcd), 32'd0);
        press(4'b1100, 8, 6);
        step(4'b0, 1'b1, 1'b0, 1'b0);
        chk("t4_prio", 32'(bcd), 32'd2);

        // 5: halt beats tick; presses ignored while stopped; restart then resume
        step(4'b0, 1'b1, 1'b1, 1'b0);
        chk("t5_halt_bcd", 32'(bcd), 32'd4);
        chk("t5_halt_moving", 32'(moving), 32'd0);
        press(4'b1000, 8, 6);
        step(4'b0, 1'b1, 1'b0, 1'b0);
        chk("t5_stopped", 32'(bcd), 32'd4);
        step(4'b0, 1'b0, 1'b0, 1'b1);
        idle(2);
        press(4'b1000, 8, 6);
        step(4'b0, 1'b1, 1'b0, 1'b0);
        chk("t5_resume", 32'(bcd), 32'd3);
        chk("t5_moving", 32'(moving), 32'd1);

        // 6: asynchronous reset between clock edges
        #3;
        rst_n = 1'b0;
        #1;
        chk("t6_bcd", 32'(bcd), 32'd4);
        chk("t6_moving", 32'(moving), 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);

        // Random phase
        hold = 0;
        cur  = 4'b0;
        for (int i = 0; i < 3000; i++) begin
            if (hold == 0) begin
                cur  = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'b0;
                hold = $urandom_range(1, 10);
            end
            hold--;
            t  = ($urandom_range(0, 7) == 0);
            h  = !m_stopped && ($urandom_range(0, 79) == 0);
            rs = m_stopped && ($urandom_range(0, 3) == 0);
            step(cur, t, h, rs);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
